inst_fetch_unit: RTL

- Parametrised instruction fetch stage: owns the PC, synchronous-read instruction memory and a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake, with per-instruction PC.
- Adds what the fixed 16x4096 fetch lacks: backpressure without losing fetches, branch redirect with flush, a runtime program-load write port, and generic word/address widths.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/inst_fetch_unit_if.sv | 21 ++
 rtl/inst_fetch_unit_fifo.sv | 66 ++++++
 rtl/inst_fetch_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  localparam int DEF_INST_W     = 16;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_RESET_PC   = 0;

  // Value presented on the instruction bus whenever no instruction is valid.
  localparam logic [DEF_INST_W-1:0] NOP_INST = 16'h0000;

  // Prefetch queue payload: an instruction word tagged with its address.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-to-decode handshake bundle: head instruction, its PC, queue occupancy and ready.
interface inst_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int INST_W     = DEF_INST_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              o_valid;
  logic [INST_W-1:0] o_instruction;
  logic [ADDR_W-1:0] o_pc;
  logic [CNT_W-1:0]  o_count;
  logic              i_ready;

  // Fetch side drives the instruction, decode side drives ready.
  modport master (output o_valid, o_instruction, o_pc, o_count, input i_ready);
  modport slave  (input o_valid, o_instruction, o_pc, o_count, output i_ready);

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Prefetch queue: power-of-two ring buffer with push/pop/flush and a head output.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = DEF_FIFO_DEPTH,
  parameter type T     = fetch_entry_t
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  T                           i_data,
  output T                           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T                 storage_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Next pointers and occupancy; a flush wins over any push or pop.
  always_comb begin
    do_pop   = i_pop && (count_q != '0) && !i_flush;
    do_push  = i_push && ((count_q != FULL_CNT) || do_pop) && !i_flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone defines what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) storage_q[wr_ptr_q] <= i_data;
  end

  assign o_head  = storage_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, synchronous-read program memory with a load port,
// and a prefetch queue feeding decode over a valid/ready handshake.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                INST_W     = DEF_INST_W,
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stop,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [INST_W-1:0] i_wr_data,
  inst_fetch_unit_if.master dec_if
);
  localparam int MEM_DEPTH = 2 ** ADDR_W;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] instruction;
  } entry_t;

  logic [INST_W-1:0] mem [MEM_DEPTH];
  logic [INST_W-1:0] rd_data_q;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
  logic              inflight_q, inflight_d;

  logic              issue, push, pop, flush, head_valid;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  fifo_count;
  entry_t            push_entry, head_entry;

  // Issue/push/pop decisions and next PC; queued plus in-flight entries never
  // exceed the queue depth, so a returning read always has a slot.
  always_comb begin
    occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    head_valid = (fifo_count != '0);
    flush      = i_redirect;
    issue      = !i_redirect && !i_stop && (occupancy < DEPTH_L);
    push       = inflight_q && !i_redirect && !i_stop;
    pop        = head_valid && dec_if.i_ready && !i_redirect && !i_stop;
    pc_d       = pc_q;
    rd_pc_d    = rd_pc_q;
    inflight_d = inflight_q;
    if (i_redirect) begin
      pc_d       = i_redirect_pc;
      inflight_d = 1'b0;
    end else if (!i_stop) begin
      inflight_d = issue;
      if (issue) begin
        pc_d    = pc_q + ADDR_W'(1);
        rd_pc_d = pc_q;
      end
    end
  end

  // PC and in-flight read tracking.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q       <= RESET_PC;
      rd_pc_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rd_pc_q    <= rd_pc_d;
      inflight_q <= inflight_d;
    end
  end

  // Program memory: registered read, old data returned on a same-address write.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    if (issue)   rd_data_q      <= mem[pc_q];
  end

  assign push_entry = '{pc: rd_pc_q, instruction: rd_data_q};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (flush),
    .i_data  (push_entry),
    .o_head  (head_entry),
    .o_count (fifo_count)
  );

  assign dec_if.o_valid       = head_valid;
  assign dec_if.o_instruction = head_valid ? head_entry.instruction : INST_W'(NOP_INST);
  assign dec_if.o_pc          = head_valid ? head_entry.pc : '0;
  assign dec_if.o_count       = fifo_count;

endmodule
